// File: rtl/load_store_unit.sv
// Data-memory stage: byte/half/word loads and stores against a
// word-organised RAM with a fixed number of wait states.
module load_store_unit #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  MemSize,
  input  logic        MemUnsigned,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        AddrErr
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  localparam int WORDS = 1 << DEPTH_LOG2;

  logic [31:0] mem [WORDS];

  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic req, bad, commit, go;
  logic stall_i, err_i;
  logic [DEPTH_LOG2-1:0] idx;
  logic [31:0] word, wide, load;
  logic [3:0] be;
  logic [7:0] lane_b;
  logic [15:0] lane_h;
  logic unused_addr;

  assign unused_addr = ^Addr[31:DEPTH_LOG2+2];

  assign idx  = Addr[DEPTH_LOG2+1:2];
  assign word = mem[idx];
  assign req  = MemRead | MemWrite;

  assign bad = (MemRead & MemWrite)
             | (MemSize == 2'b11)
             | ((MemSize == 2'b01) & Addr[0])
             | ((MemSize == 2'b10) & (|Addr[1:0]));

  // The accepting IDLE cycle is itself the first stall cycle,
  // so WAIT only covers the remaining WAIT_STATES cycles.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    commit   = 1'b0;
    stall_i  = 1'b0;
    err_i    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req && bad) begin
          err_i = 1'b1;
        end else if (req) begin
          stall_i = 1'b1;
          if (WAIT_STATES == 0) begin
            commit   = 1'b1;
            state_nx = DONE;
          end else begin
            cnt_nx   = 4'(WAIT_STATES - 1);
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        stall_i = 1'b1;
        if (cnt == 4'd0) begin
          commit   = 1'b1;
          state_nx = DONE;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign Stall   = stall_i & rst_n;
  assign AddrErr = err_i & rst_n;
  assign go      = commit & rst_n;

  always_comb begin
    be   = 4'b0000;
    wide = WriteData;
    unique case (MemSize)
      2'b00: begin
        be   = 4'b0001 << Addr[1:0];
        wide = {4{WriteData[7:0]}};
      end
      2'b01: begin
        be   = Addr[1] ? 4'b1100 : 4'b0011;
        wide = {2{WriteData[15:0]}};
      end
      2'b10: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  assign lane_b = word[{Addr[1:0], 3'b000} +: 8];
  assign lane_h = Addr[1] ? word[31:16] : word[15:0];

  always_comb begin
    unique case (MemSize)
      2'b00: load = {{24{~MemUnsigned & lane_b[7]}}, lane_b};
      2'b01: load = {{16{~MemUnsigned & lane_h[15]}}, lane_h};
      default: load = word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (go && MemWrite) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem[idx][8*k +: 8] <= wide[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      ReadData <= 32'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (go && MemRead) ReadData <= load;
    end
  end

endmodule
